dram_subword_ctrl: RTL

Downstream of the core bus arbiter: consumes the arbitrated DRAM command (`w_dram_addr/wdata/we_t/ctrl/le`) and returns `w_dram_odata`/`w_dram_busy`. Converts byte/halfword/word loads and stores into word-only accesses on a req/ack memory port. Sub-word stores use read-modify-write, loads are sign- or zero-extended, misaligned accesses are rejected, and a stalled memory is timed out.

---
 rtl/dram_subword_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dram_subword_ctrl.sv
// Byte/halfword/word DRAM access controller over a word-only req/ack memory port.
// Sub-word stores use read-modify-write; loads are sign/zero extended; misaligned or
// malformed commands are rejected and a stalled memory beat is aborted after TIMEOUT cycles.
module dram_subword_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] w_dram_addr,
    input  logic [31:0] w_dram_wdata,
    input  logic        w_dram_we_t,
    input  logic        w_dram_le,
    input  logic [2:0]  w_dram_ctrl,
    output logic [31:0] w_dram_odata,
    output logic        w_dram_busy,
    output logic        w_dram_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRd, StRmwRd, StWr} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [31:0]   odata_q, odata_d;
    logic [31:0]   maddr_q, maddr_d;
    logic [31:0]   mwdata_q, mwdata_d;
    logic          req_q, we_q, busy_q, err_q;
    logic          err_d;

    logic          reject;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic [31:0]   merged;

    // Decide whether an IDLE strobe is malformed, misaligned or ambiguous.
    always_comb begin
        reject = 1'b0;
        if (w_dram_le && w_dram_we_t) begin
            reject = 1'b1;
        end else if (w_dram_le) begin
            case (w_dram_ctrl)
                3'b000, 3'b100: reject = 1'b0;
                3'b001, 3'b101: reject = w_dram_addr[0];
                3'b010:         reject = (w_dram_addr[1:0] != 2'b00);
                default:        reject = 1'b1;
            endcase
        end else if (w_dram_we_t) begin
            case (w_dram_ctrl)
                3'b000:  reject = 1'b0;
                3'b001:  reject = w_dram_addr[0];
                3'b010:  reject = (w_dram_addr[1:0] != 2'b00);
                default: reject = 1'b1;
            endcase
        end
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        case (addr_lo_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (ctrl_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'd0, lane_b};
            3'b101:  load_val = {16'd0, lane_h};
            default: load_val = mem_rdata;
        endcase

        merged = mem_rdata;
        if (ctrl_q[0]) begin
            if (addr_lo_q[1]) merged[31:16] = wdata_q;
            else              merged[15:0]  = wdata_q;
        end else begin
            case (addr_lo_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Next-state, timeout counter and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        addr_lo_d = addr_lo_q;
        wdata_d   = wdata_q;
        odata_d   = odata_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        err_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (w_dram_le || w_dram_we_t) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        ctrl_d    = w_dram_ctrl;
                        addr_lo_d = w_dram_addr[1:0];
                        wdata_d   = w_dram_wdata[15:0];
                        maddr_d   = {w_dram_addr[31:2], 2'b00};
                        cnt_d     = '0;
                        if (w_dram_le) begin
                            state_d = StRd;
                        end else if (w_dram_ctrl == 3'b010) begin
                            state_d  = StWr;
                            mwdata_d = w_dram_wdata;
                        end else begin
                            state_d = StRmwRd;
                        end
                    end
                end
            end
            StRd, StRmwRd, StWr: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (state_q == StRd) begin
                        odata_d = load_val;
                        state_d = StIdle;
                    end else if (state_q == StRmwRd) begin
                        mwdata_d = merged;
                        state_d  = StWr;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == CntLast) begin
                    // Abort: an RMW stopped in its read phase never issues the write.
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops any access in flight immediately.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ctrl_q    <= 3'b000;
            addr_lo_q <= 2'b00;
            wdata_q   <= 16'd0;
            odata_q   <= 32'd0;
            maddr_q   <= 32'd0;
            mwdata_q  <= 32'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            addr_lo_q <= addr_lo_d;
            wdata_q   <= wdata_d;
            odata_q   <= odata_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            req_q     <= (state_d != StIdle);
            we_q      <= (state_d == StWr);
            busy_q    <= (state_d != StIdle);
            err_q     <= err_d;
        end
    end

    assign w_dram_odata = odata_q;
    assign w_dram_busy  = busy_q;
    assign w_dram_err   = err_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = maddr_q;
    assign mem_wdata    = mwdata_q;

endmodule
